io_port_unit: RTL and testbench

//   Memory-less I/O port pair between the CPU datapath and the outside world.
//   - In-port: captures external data on an asynchronous strobe into a one-entry

---
 rtl/io_port_unit_if.sv | 28 ++
 rtl/io_port_unit.sv | 100 ++++++++++
 tb/tb_io_port_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_unit_if.sv
// Signal bundle between the CPU datapath / outside world and the I/O port unit.
// The unit itself connects via the slave modport; the driving side uses master.
interface io_port_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] bus_mux_out;
  logic              out_port_in;
  logic [DATA_W-1:0] out_port_data;
  logic              out_strobe;
  logic [DATA_W-1:0] ext_in_data;
  logic              strobe;
  logic              in_port_out;
  logic [DATA_W-1:0] in_port_bus;
  logic              in_ready;
  logic              in_overrun;
  logic              int_req;
  logic              int_ack;

  modport master (
    output bus_mux_out, out_port_in, ext_in_data, strobe, in_port_out, int_ack,
    input  out_port_data, out_strobe, in_port_bus, in_ready, in_overrun, int_req
  );

  modport slave (
    input  bus_mux_out, out_port_in, ext_in_data, strobe, in_port_out, int_ack,
    output out_port_data, out_strobe, in_port_bus, in_ready, in_overrun, int_req
  );
endinterface

// File: rtl/io_port_unit.sv
// I/O port pair: strobe-captured one-entry in-port buffer with interrupt and
// overrun tracking, plus a registered out-port with a load strobe.
module io_port_unit #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  io_port_unit_if.slave port
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} in_state_e;

  in_state_e               state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    strobe_prev_q;
  logic                    rd_prev_q;
  logic [DATA_W-1:0]       buf_q;
  logic                    overrun_q;
  logic                    int_req_q;
  logic                    int_req_d;
  logic [DATA_W-1:0]       out_data_q;
  logic                    out_strobe_q;
  logic                    cap;
  logic                    rd;

  // Reset to all-ones so a strobe already high at reset release is not seen as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q        <= '1;
      strobe_prev_q <= 1'b1;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], port.strobe};
      strobe_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cap = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
  assign rd  = port.in_port_out & ~rd_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= EMPTY;
      buf_q     <= '0;
      overrun_q <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      rd_prev_q <= port.in_port_out;
      case (state_q)
        EMPTY: begin
          if (cap) begin
            buf_q   <= port.ext_in_data;
            state_q <= FULL;
          end
        end
        FULL: begin
          // A read coinciding with a capture consumes the old value, so no overrun.
          if (cap) begin
            buf_q     <= port.ext_in_data;
            overrun_q <= ~rd;
          end else if (rd) begin
            state_q   <= EMPTY;
            overrun_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    int_req_d = int_req_q;
    if (cap) begin
      int_req_d = 1'b1;
    end else if (port.int_ack || rd) begin
      int_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      int_req_q    <= 1'b0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
    end else begin
      int_req_q    <= int_req_d;
      out_strobe_q <= port.out_port_in;
      if (port.out_port_in) begin
        out_data_q <= port.bus_mux_out;
      end
    end
  end

  assign port.in_port_bus   = buf_q;
  assign port.in_ready      = (state_q == FULL);
  assign port.in_overrun    = overrun_q;
  assign port.int_req       = int_req_q;
  assign port.out_port_data = out_data_q;
  assign port.out_strobe    = out_strobe_q;

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: stimulus queues expectations, a negedge
// monitor pops them on out-strobe pulses, IntReq rises and status sample requests.
module tb_io_port_unit;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic chk_req = 1'b0;
  logic ireq_prev = 1'b0;

  typedef struct {
    logic [31:0] bus;
    logic        ready;
    logic        ov;
    int          cyc;
  } int_exp_t;

  typedef struct {
    string       name;
    logic        ready;
    logic        ov;
    logic        ireq;
    logic        ostr;
    logic [31:0] bus;
    logic [31:0] opd;
  } st_exp_t;

  int_exp_t    int_q[$];
  st_exp_t     st_q[$];
  logic [31:0] out_q[$];

  io_port_unit_if #(.DATA_W(32)) bus_if ();

  io_port_unit #(.DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .port  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the relevant queue whenever the DUT presents an event.
  always @(negedge clk) begin
    if (bus_if.out_strobe) begin
      if (out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_strobe unexpected pulse actual data=%h required no pulse", bus_if.out_port_data);
      end else begin
        logic [31:0] e;
        e = out_q.pop_front();
        chk("out_port_data", bus_if.out_port_data, e);
      end
    end
    if (bus_if.int_req && !ireq_prev) begin
      if (int_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL int_req unexpected rise actual=1 required=0 cycle %0d", cyc);
      end else begin
        int_exp_t ie;
        ie = int_q.pop_front();
        chk("int_rise_cycle", cyc, ie.cyc);
        chk("int_in_port_bus", bus_if.in_port_bus, ie.bus);
        chk("int_in_ready", {31'd0, bus_if.in_ready}, {31'd0, ie.ready});
        chk("int_in_overrun", {31'd0, bus_if.in_overrun}, {31'd0, ie.ov});
      end
    end
    ireq_prev = bus_if.int_req;
    if (chk_req) begin
      st_exp_t s;
      s = st_q.pop_front();
      chk({s.name, ".in_ready"}, {31'd0, bus_if.in_ready}, {31'd0, s.ready});
      chk({s.name, ".in_overrun"}, {31'd0, bus_if.in_overrun}, {31'd0, s.ov});
      chk({s.name, ".int_req"}, {31'd0, bus_if.int_req}, {31'd0, s.ireq});
      chk({s.name, ".out_strobe"}, {31'd0, bus_if.out_strobe}, {31'd0, s.ostr});
      chk({s.name, ".in_port_bus"}, bus_if.in_port_bus, s.bus);
      chk({s.name, ".out_port_data"}, bus_if.out_port_data, s.opd);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_status(input string name, input logic ready, input logic ov,
                               input logic ireq, input logic ostr,
                               input logic [31:0] bus, input logic [31:0] opd);
    st_q.push_back('{name, ready, ov, ireq, ostr, bus, opd});
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic strobe_rise(input logic [31:0] d, input logic ov);
    @(posedge clk);
    #1;
    bus_if.ext_in_data = d;
    bus_if.strobe      = 1'b1;
    int_q.push_back('{d, 1'b1, ov, cyc + 3});
  endtask

  task automatic pulse(input int which, input int n);
    if (which == 0) bus_if.in_port_out = 1'b1;
    else            bus_if.int_ack     = 1'b1;
    wait_cycles(n);
    bus_if.in_port_out = 1'b0;
    bus_if.int_ack     = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus_if.strobe      = 1'b1;
    bus_if.ext_in_data = '0;
    bus_if.bus_mux_out = '0;
    bus_if.out_port_in = 1'b0;
    bus_if.in_port_out = 1'b0;
    bus_if.int_ack     = 1'b0;

    // Strobe held high across reset release must not capture.
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(10);
    expect_status("reset", 0, 0, 0, 0, 32'h0, 32'h0);

    // Basic capture, exact latency, then a multi-cycle read counts once.
    bus_if.strobe = 1'b0;
    wait_cycles(2);
    strobe_rise(32'hDEADBEEF, 1'b0);
    wait_cycles(5);
    expect_status("captured", 1, 0, 1, 0, 32'hDEADBEEF, 32'h0);
    bus_if.strobe = 1'b0;
    pulse(0, 3);
    pulse(1, 1);
    expect_status("after_read", 0, 0, 0, 0, 32'hDEADBEEF, 32'h0);

    // Overrun: two captures without a read.
    strobe_rise(32'h1, 1'b0);
    wait_cycles(5);
    bus_if.strobe = 1'b0;
    wait_cycles(2);
    pulse(1, 1);
    expect_status("acked", 1, 0, 0, 0, 32'h1, 32'h0);
    strobe_rise(32'h2, 1'b1);
    wait_cycles(5);
    expect_status("overrun", 1, 1, 1, 0, 32'h2, 32'h0);
    bus_if.strobe = 1'b0;
    pulse(0, 1);
    expect_status("overrun_read", 0, 0, 0, 0, 32'h2, 32'h0);

    // Capture and read in the same cycle while FULL.
    strobe_rise(32'h5, 1'b0);
    wait_cycles(5);
    bus_if.strobe = 1'b0;
    wait_cycles(2);
    pulse(1, 1);
    expect_status("full5", 1, 0, 0, 0, 32'h5, 32'h0);
    strobe_rise(32'h6, 1'b0);
    wait_cycles(2);
    bus_if.in_port_out = 1'b1;
    expect_status("cap_rd_old", 1, 0, 0, 0, 32'h5, 32'h0);
    wait_cycles(1);
    bus_if.in_port_out = 1'b0;
    wait_cycles(2);
    expect_status("cap_rd_new", 1, 0, 1, 0, 32'h6, 32'h0);
    bus_if.strobe = 1'b0;

    // Out-port: single load, then three back-to-back loads.
    wait_cycles(1);
    bus_if.bus_mux_out = 32'h0000_00A5;
    bus_if.out_port_in = 1'b1;
    out_q.push_back(32'h0000_00A5);
    wait_cycles(1);
    bus_if.out_port_in = 1'b0;
    wait_cycles(3);
    expect_status("out_single", 1, 0, 1, 0, 32'h6, 32'hA5);
    wait_cycles(1);
    for (int i = 1; i <= 3; i++) begin
      bus_if.bus_mux_out = 32'h11 * i;
      bus_if.out_port_in = 1'b1;
      out_q.push_back(32'h11 * i);
      wait_cycles(1);
    end
    bus_if.out_port_in = 1'b0;
    wait_cycles(3);
    expect_status("out_triple", 1, 0, 1, 0, 32'h6, 32'h33);

    // Reset while a strobe edge is still in the synchronizer.
    wait_cycles(1);
    bus_if.ext_in_data = 32'h77;
    bus_if.strobe      = 1'b1;
    wait_cycles(1);
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);
    bus_if.strobe = 1'b0;
    wait_cycles(10);
    expect_status("reset_mid", 0, 0, 0, 0, 32'h0, 32'h0);

    chk("out_queue_drained", out_q.size(), 0);
    chk("int_queue_drained", int_q.size(), 0);
    chk("status_queue_drained", st_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
